// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address/word geometry and controller state encodings.
package dcache_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;
    localparam int OFF_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the data cache. One word write port and one
// full-line write port; the line port wins if both are asserted together.
module dcache_line_array
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int TAG_W  = 12,
    parameter int LINE_W = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [$clog2(LINES)-1:0] idx,
    input  logic [OFF_W-1:0]         off,
    input  logic                     word_we,
    input  logic [WORD_W-1:0]        word_data,
    input  logic                     line_we,
    input  logic [TAG_W-1:0]         line_tag,
    input  logic [LINE_W-1:0]        line_data,
    input  logic                     clean_we,
    output logic [TAG_W-1:0]         rd_tag,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [LINE_W-1:0]        rd_line
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    // Only the status bits are reset; tags and data are meaningless while invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end else if (clean_we) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][off*WORD_W +: WORD_W] <= word_data;
        end
    end

    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Hits complete in the request cycle; misses stall via cpu_ready=0 while WB/FILL run.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES = 4,
    parameter int WPL   = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [WORD_W-1:0]       cpu_wdata,
    output logic [WORD_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WPL*WORD_W-1:0]   mem_wdata,
    input  logic [WPL*WORD_W-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt,
    output logic [1:0]              fsm_state
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = WPL * WORD_W;

    state_t state, next_state;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              rd_dirty;
    logic [LINE_W-1:0] rd_line;
    logic              hit;
    logic              word_we;
    logic              line_we;
    logic              clean_we;
    logic              hit_inc;
    logic              miss_inc;

    assign req_off   = cpu_addr[OFF_W-1:0];
    assign req_idx   = cpu_addr[OFF_W +: IDX_W];
    assign req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign fsm_state = state;

    dcache_line_array #(
        .LINES  (LINES),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_lines (
        .clk       (clk),
        .reset_n   (reset_n),
        .idx       (req_idx),
        .off       (req_off),
        .word_we   (word_we),
        .word_data (cpu_wdata),
        .line_we   (line_we),
        .line_tag  (req_tag),
        .line_data (mem_rdata),
        .clean_we  (clean_we),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Request index is held stable during a miss, so the victim is always line req_idx.
    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        word_we    = 1'b0;
        line_we    = 1'b0;
        clean_we   = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!(cpu_read || cpu_write)) begin
                    cpu_ready = 1'b1;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    hit_inc   = 1'b1;
                    if (cpu_write) word_we   = 1'b1;
                    else           cpu_rdata = rd_line[req_off*WORD_W +: WORD_W];
                end else begin
                    miss_inc   = 1'b1;
                    next_state = (rd_valid && rd_dirty) ? WB : FILL;
                end
            end
            WB: begin
                mem_write = 1'b1;
                mem_addr  = {rd_tag, req_idx, {OFF_W{1'b0}}};
                mem_wdata = rd_line;
                if (mem_ack) begin
                    clean_we   = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                mem_read = 1'b1;
                mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ack) begin
                    line_we    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // While reset is held the CPU side must look idle-but-not-ready.
        if (!reset_n) begin
            cpu_ready = 1'b0;
            cpu_rdata = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc)  hit_cnt  <= hit_cnt + CNT_W'(1);
            if (miss_inc) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

endmodule
